// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // Result width of the op units feeding the sink.
    localparam int ALU_K = 8;

    localparam logic [3:0] STATUS_OK  = 4'b0000;
    localparam logic [3:0] STATUS_OVF = 4'b1001;
    localparam int STATUS_ERR_BIT = 3;

    // Buffer occupancy: 0, 1 or 2 entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sink_state_t;

    typedef struct packed {
        logic [ALU_K-1:0] res;
        logic [3:0]       st;
    } alu_entry_t;

    // True when the op unit flagged an error; its result is then unreliable.
    function automatic logic is_err(input logic [3:0] st);
        return st[STATUS_ERR_BIT];
    endfunction

endpackage

// File: rtl/alu_err_counter.sv
// Saturating event counter with synchronous clear.
// Latency: cnt reflects inc/clr one cycle after the edge that samples them.
// Backpressure: none; inc is counted every cycle it is high until saturation.
//
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous reset, active-high
//   inc    count one event this cycle
//   clr    clear to zero; takes priority over inc
//   cnt    current count, sticks at all-ones
module alu_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge i_clk) begin
        if (i_rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_result_sink.sv
// Consumer of op-unit results: captures, sanitises, buffers two entries, tracks errors.
// Latency: an entry pushed at edge N is presented on o_result/o_status after edge N.
// Backpressure: o_ready drops while two entries are held; it is a decode of registered state only.
//
// Ports:
//   i_clk, i_rst                 clock and synchronous active-high reset
//   cache_result, cache_status   op-unit result/status pair, valid with i_valid
//   i_valid / o_ready            upstream handshake (push = i_valid & o_ready)
//   o_result, o_status, o_valid  head entry towards downstream
//   i_ready                      downstream accepts head (pop = o_valid & i_ready)
//   i_clr_err                    clears sticky error flag and error count
//   o_err_sticky, o_err_cnt      error tracking over accepted entries
module alu_result_sink
    import alu_pkg::*;
#(
    parameter int K     = ALU_K,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [K-1:0]     cache_result,
    input  logic [3:0]       cache_status,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [K-1:0]     o_result,
    output logic [3:0]       o_status,
    output logic             o_valid,
    input  logic             i_ready,
    input  logic             i_clr_err,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_err_cnt
);

    sink_state_t state_q;
    alu_entry_t  slot_q [DEPTH];
    alu_entry_t  in_entry;
    logic        push;
    logic        pop;
    logic        err_push;

    // An erroring op unit may drive X on its result; store a clean zero
    // instead so nothing unknown ever reaches the downstream datapath.
    always_comb begin
        in_entry     = '0;
        in_entry.res = is_err(cache_status) ? '0 : cache_result;
        in_entry.st  = cache_status;
    end

    assign o_valid  = (state_q != EMPTY);
    assign o_ready  = (state_q != FULL);
    assign push     = i_valid & o_ready;
    assign pop      = o_valid & i_ready;
    assign err_push = push & is_err(cache_status);

    // Head is always slot 0, so the outputs come straight from a register
    // and simply hold their last value once the buffer drains.
    assign o_result = slot_q[0].res;
    assign o_status = slot_q[0].st;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        slot_q[0] <= in_entry;
                        state_q   <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Head leaves and the new entry takes its place.
                        slot_q[0] <= in_entry;
                    end else if (push) begin
                        slot_q[1] <= in_entry;
                        state_q   <= FULL;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // o_ready is low here, so only a pop can happen.
                    if (pop) begin
                        slot_q[0] <= slot_q[1];
                        state_q   <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    // Clear beats a coincident error push; the entry itself is still buffered.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_err) begin
            o_err_sticky <= 1'b0;
        end else if (err_push) begin
            o_err_sticky <= 1'b1;
        end
    end

    alu_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .inc   (err_push),
        .clr   (i_clr_err),
        .cnt   (o_err_cnt)
    );

endmodule

// File: tb/tb_alu_result_sink.sv
module tb_alu_result_sink;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] cache_result;
    logic [3:0] cache_status;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_result;
    logic [3:0] o_status;
    logic       o_valid;
    logic       i_ready;
    logic       i_clr_err;
    logic       o_err_sticky;
    logic [7:0] o_err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    alu_result_sink dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cache_result (cache_result),
        .cache_status (cache_status),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_result     (o_result),
        .o_status     (o_status),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .i_clr_err    (i_clr_err),
        .o_err_sticky (o_err_sticky),
        .o_err_cnt    (o_err_cnt)
    );

    // Reference model: a queue of at most two entries plus error bookkeeping.
    typedef struct {
        logic [7:0] r;
        logic [3:0] s;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_last_r = 8'h00;
    logic [3:0] m_last_s = 4'h0;
    bit         m_sticky = 1'b0;
    int         m_cnt    = 0;

    wire [22:0] obs = {o_valid, o_ready, o_result, o_status, o_err_sticky, o_err_cnt};

    function automatic logic [22:0] exp_out();
        logic v, r;
        v = (mq.size() > 0);
        r = (mq.size() < 2);
        return {v, r, m_last_r, m_last_s, m_sticky, 8'(m_cnt)};
    endfunction

    // Advance one clock and update the model from the inputs held across the edge.
    task automatic tick();
        bit   push, pop, err;
        ent_t e;
        push = i_valid && (mq.size() < 2);
        pop  = i_ready && (mq.size() > 0);
        err  = cache_status[3];
        e.s  = cache_status;
        e.r  = err ? 8'h00 : cache_result;
        @(posedge i_clk);
        if (i_rst) begin
            mq.delete();
            m_last_r = 8'h00;
            m_last_s = 4'h0;
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
            if (i_clr_err) begin
                m_sticky = 1'b0;
                m_cnt    = 0;
            end else if (push && err) begin
                m_sticky = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (mq.size() > 0) begin
                m_last_r = mq[0].r;
                m_last_s = mq[0].s;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_clr_err    = 1'b0;
        cache_result = 8'h00;
        cache_status = 4'h0;
    endtask

    task automatic drain();
        idle_inputs();
        i_ready = 1'b1;
        repeat (3) tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        i_rst = 1'b0;
        total++;
        if (obs !== 23'h200000) begin
            bad++;
            $display("FAIL reset_initial got=%h exp=%h", obs, 23'h200000);
        end
        // One entry buffered, then reset mid-stream for two cycles.
        i_valid = 1'b1; cache_result = 8'h77; cache_status = 4'h0;
        tick();
        i_valid = 1'b0;
        total++;
        if (obs !== exp_out() || o_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_prefill got=%h exp=%h", obs, exp_out());
        end
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_err_cnt !== 8'h00 || obs !== exp_out()) begin
            bad++;
            $display("FAIL reset_midstream got=%h exp=%h", obs, exp_out());
        end
    endtask

    task automatic test_single();
        i_valid = 1'b1; cache_result = 8'h05; cache_status = 4'h0; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o_result !== 8'h05 || o_status !== 4'h0) begin
            bad++;
            $display("FAIL single_capture got v=%b r=%h exp v=1 r=05", o_valid, o_result);
        end
        tick();
        total++;
        if (o_valid !== 1'b0 || obs !== exp_out()) begin
            bad++;
            $display("FAIL single_pop got=%h exp=%h", obs, exp_out());
        end
        i_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; cache_result = vals[i]; cache_status = 4'h0;
            tick();
        end
        total++;
        if (o_ready !== 1'b0 || o_result !== 8'h11 || obs !== exp_out()) begin
            bad++;
            $display("FAIL bp_full got=%h exp=%h", obs, exp_out());
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        total++;
        if (o_valid !== 1'b1 || o_result !== 8'h22 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_order got v=%b r=%h rdy=%b exp v=1 r=22 rdy=1", o_valid, o_result, o_ready);
        end
        tick();
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || obs !== exp_out()) begin
            bad++;
            $display("FAIL bp_drained got=%h exp=%h (33 must not be captured)", obs, exp_out());
        end
        i_ready = 1'b0;
    endtask

    task automatic test_overflow();
        i_valid = 1'b1; cache_result = 8'bx; cache_status = 4'b1001;
        tick();
        idle_inputs();
        total++;
        if (o_result !== 8'h00 || o_status !== 4'b1001 || o_err_sticky !== 1'b1 ||
            o_err_cnt !== 8'd1 || obs !== exp_out()) begin
            bad++;
            $display("FAIL overflow got=%h exp=%h", obs, exp_out());
        end
        drain();
    endtask

    task automatic test_saturation();
        i_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            i_valid = 1'b1; cache_result = 8'($urandom); cache_status = 4'b1000 | 4'($urandom_range(0, 7));
            tick();
        end
        total++;
        if (o_err_cnt !== 8'd255 || o_err_sticky !== 1'b1 || obs !== exp_out()) begin
            bad++;
            $display("FAIL saturate got cnt=%0d exp cnt=255 (obs=%h model=%h)", o_err_cnt, obs, exp_out());
        end
        i_clr_err = 1'b1; cache_result = 8'h5A; cache_status = 4'b1001;
        tick();
        i_clr_err = 1'b0; i_valid = 1'b0;
        total++;
        if (o_err_cnt !== 8'd0 || o_err_sticky !== 1'b0 || o_valid !== 1'b1 ||
            o_status !== 4'b1001 || o_result !== 8'h00) begin
            bad++;
            $display("FAIL clear_wins got=%h exp cnt=0 sticky=0 v=1 st=9 r=00", obs);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            i_valid = 1'b1; cache_result = 8'(i); cache_status = 4'h0;
            tick();
            total++;
            if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_result !== 8'(i)) begin
                bad++;
                $display("FAIL stream_%0d got v=%b rdy=%b r=%h exp v=1 rdy=1 r=%h",
                         i, o_valid, o_ready, o_result, 8'(i));
            end
        end
        i_valid = 1'b0;
        tick();
        total++;
        if (o_valid !== 1'b0 || obs !== exp_out()) begin
            bad++;
            $display("FAIL stream_end got=%h exp=%h", obs, exp_out());
        end
        i_ready = 1'b0;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            i_valid      = ($urandom_range(0, 3) != 0);
            i_ready      = ($urandom_range(0, 2) != 0);
            i_clr_err    = ($urandom_range(0, 15) == 0);
            cache_status = 4'($urandom);
            cache_result = cache_status[3] ? 8'bx : 8'($urandom);
            tick();
            total++;
            if (obs !== exp_out()) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
        drain();
    endtask

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
